// File: rtl/rv_data_bus.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv_data_bus : RV32 data-side interconnect, RAM region plus MMIO page       |
// |   (GPIO, timer with sticky compare IRQ, test-status). Rev 1.0             |
// +--------------------------------------------------------------------------+
module rv_data_bus #(
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          GPIO_W    = 8,
  parameter int          TIMER_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_we_i,
  input  logic [3:0]        cpu_be_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_be_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              irq_o,
  output logic              test_done_o,
  output logic              test_pass_o
);

  localparam logic [5:0] C_OFF_GPIO  = 6'd0;
  localparam logic [5:0] C_OFF_COUNT = 6'd1;
  localparam logic [5:0] C_OFF_CMP   = 6'd2;
  localparam logic [5:0] C_OFF_CTRL  = 6'd3;
  localparam logic [5:0] C_OFF_TEST  = 6'd4;

  logic               w_mmio;
  logic [5:0]         w_off;
  logic               w_mwe;
  logic [31:0]        w_bmask;
  logic               w_unused;

  logic [GPIO_W-1:0]  gpio_q,  gpio_d;
  logic [TIMER_W-1:0] count_q, count_d;
  logic [TIMER_W-1:0] cmp_q,   cmp_d;
  logic               en_q,    en_d;
  logic               irq_q,   irq_d;
  logic               done_q,  done_d;
  logic               pass_q,  pass_d;
  logic               sel_mmio_q;
  logic [31:0]        mmio_rdata_q, mmio_rdata_d;
  logic [31:0]        w_gpio_ext, w_count_ext, w_cmp_ext;
  logic               w_irq_set, w_irq_clr;

  assign w_mmio   = (cpu_addr_i[31:8] == MMIO_BASE[31:8]);
  assign w_off    = cpu_addr_i[7:2];
  assign w_mwe    = cpu_we_i & w_mmio;
  assign w_bmask  = {{8{cpu_be_i[3]}}, {8{cpu_be_i[2]}}, {8{cpu_be_i[1]}}, {8{cpu_be_i[0]}}};
  assign w_unused = ^cpu_addr_i[1:0];

  assign ram_we_o   = cpu_we_i & ~w_mmio;
  assign ram_be_o   = cpu_be_i;
  assign ram_addr_o = cpu_addr_i[RAM_AW+1:2];
  assign ram_data_o = cpu_data_i;

  assign gpio_o      = gpio_q;
  assign irq_o       = irq_q;
  assign test_done_o = done_q;
  assign test_pass_o = pass_q;
  assign cpu_data_o  = sel_mmio_q ? mmio_rdata_q : ram_data_i;

  // Compare uses the pre-increment count; a same-cycle clear loses to a set.
  assign w_irq_set = en_q & (count_q == cmp_q);
  assign w_irq_clr = w_mwe & (w_off == C_OFF_CTRL) & cpu_be_i[0] & cpu_data_i[1];

  always_comb begin
    w_gpio_ext  = '0;
    w_count_ext = '0;
    w_cmp_ext   = '0;
    w_gpio_ext[GPIO_W-1:0]   = gpio_q;
    w_count_ext[TIMER_W-1:0] = count_q;
    w_cmp_ext[TIMER_W-1:0]   = cmp_q;

    gpio_d  = gpio_q;
    count_d = en_q ? count_q + TIMER_W'(1) : count_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    irq_d   = w_irq_set | (irq_q & ~w_irq_clr);
    done_d  = done_q;
    pass_d  = pass_q;

    if (w_mwe) begin
      case (w_off)
        C_OFF_GPIO:  gpio_d  = (gpio_q & ~w_bmask[GPIO_W-1:0])
                             | (cpu_data_i[GPIO_W-1:0] & w_bmask[GPIO_W-1:0]);
        C_OFF_COUNT: count_d = (count_q & ~w_bmask[TIMER_W-1:0])
                             | (cpu_data_i[TIMER_W-1:0] & w_bmask[TIMER_W-1:0]);
        C_OFF_CMP:   cmp_d   = (cmp_q & ~w_bmask[TIMER_W-1:0])
                             | (cpu_data_i[TIMER_W-1:0] & w_bmask[TIMER_W-1:0]);
        C_OFF_CTRL:  if (cpu_be_i[0]) en_d = cpu_data_i[0];
        C_OFF_TEST: begin
          done_d = 1'b1;
          pass_d = (cpu_data_i == 32'd1);
        end
        default: ;
      endcase
    end

    case (w_off)
      C_OFF_GPIO:  mmio_rdata_d = w_gpio_ext;
      C_OFF_COUNT: mmio_rdata_d = w_count_ext;
      C_OFF_CMP:   mmio_rdata_d = w_cmp_ext;
      C_OFF_CTRL:  mmio_rdata_d = {30'd0, irq_q, en_q};
      C_OFF_TEST:  mmio_rdata_d = {30'd0, pass_q, done_q};
      default:     mmio_rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gpio_q       <= '0;
      count_q      <= '0;
      cmp_q        <= '0;
      en_q         <= 1'b0;
      irq_q        <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      sel_mmio_q   <= 1'b0;
      mmio_rdata_q <= '0;
    end else begin
      gpio_q       <= gpio_d;
      count_q      <= count_d;
      cmp_q        <= cmp_d;
      en_q         <= en_d;
      irq_q        <= irq_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      sel_mmio_q   <= w_mmio;
      mmio_rdata_q <= mmio_rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_data_bus.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rv_data_bus : randomized bench with behavioural reference model.       |
// |   Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rv_data_bus;

  localparam int C_RAM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_be = 4'h0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic [7:0]  gpio;
  logic        irq, tdone, tpass;

  rv_data_bus dut (
    .clk_i(clk), .rst_i(rst), .cpu_we_i(cpu_we), .cpu_be_i(cpu_be),
    .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata), .cpu_data_o(cpu_rdata),
    .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
    .ram_data_o(ram_wdata), .ram_data_i(ram_rdata), .gpio_o(gpio),
    .irq_o(irq), .test_done_o(tdone), .test_pass_o(tpass)
  );

  always #5 clk = ~clk;

  // Synchronous RAM fixture driven by the DUT's RAM port (read-first).
  logic [31:0] fix_mem [C_RAM_WORDS];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) fix_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= fix_mem[ram_addr];
  end

  // Reference model state
  logic [31:0] m_mem [C_RAM_WORDS];
  logic [7:0]  m_gpio;
  logic [31:0] m_count, m_cmp;
  logic        m_en, m_irq, m_done, m_pass;
  logic [31:0] m_rd_exp;
  logic        m_rd_valid;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gpio = '0; m_count = '0; m_cmp = '0;
    m_en = 1'b0; m_irq = 1'b0; m_done = 1'b0; m_pass = 1'b0;
    m_rd_valid = 1'b0; m_rd_exp = '0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // One bus cycle: drive, check everything visible, advance the model across the edge.
  task automatic step(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] data);
    logic        mmio;
    int          off, widx;
    logic [31:0] rd, n_count, g;
    logic        n_irq, n_en;
    cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = data;
    #1;
    mmio = (addr[31:8] == 24'h80_0000);
    off  = int'(addr[7:2]);
    widx = int'(addr[11:2]);
    chk("ram_we",   {31'd0, ram_we}, {31'd0, we & ~mmio});
    chk("ram_addr", {22'd0, ram_addr}, widx);
    chk("ram_be",   {28'd0, ram_be}, {28'd0, be});
    chk("ram_data", ram_wdata, data);
    chk("gpio",     {24'd0, gpio}, {24'd0, m_gpio});
    chk("irq",      {31'd0, irq}, {31'd0, m_irq});
    chk("done",     {31'd0, tdone}, {31'd0, m_done});
    chk("pass",     {31'd0, tpass}, {31'd0, m_pass});
    if (m_rd_valid) chk("rdata", cpu_rdata, m_rd_exp);

    if (mmio) begin
      case (off)
        0: rd = {24'd0, m_gpio};
        1: rd = m_count;
        2: rd = m_cmp;
        3: rd = {30'd0, m_irq, m_en};
        4: rd = {30'd0, m_pass, m_done};
        default: rd = 32'd0;
      endcase
    end else rd = m_mem[widx];

    n_count = m_en ? m_count + 32'd1 : m_count;
    n_en    = m_en;
    n_irq   = (m_en && m_count == m_cmp) || (m_irq && !(we && mmio && off == 3 && be[0] && data[1]));
    if (we && mmio) begin
      case (off)
        0: begin g = merge({24'd0, m_gpio}, data, be); m_gpio = g[7:0]; end
        1: n_count = merge(m_count, data, be);
        2: m_cmp = merge(m_cmp, data, be);
        3: if (be[0]) n_en = data[0];
        4: begin m_done = 1'b1; m_pass = (data == 32'd1); end
        default: ;
      endcase
    end
    if (we && !mmio) m_mem[widx] = merge(m_mem[widx], data, be);
    m_count = n_count; m_en = n_en; m_irq = n_irq;
    m_rd_exp = rd; m_rd_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] C_GPIO  = 32'h8000_0000;
  localparam logic [31:0] C_COUNT = 32'h8000_0004;
  localparam logic [31:0] C_CMP   = 32'h8000_0008;
  localparam logic [31:0] C_CTRL  = 32'h8000_000C;
  localparam logic [31:0] C_TEST  = 32'h8000_0010;

  initial begin
    logic [31:0] a, d;
    int off;
    for (int i = 0; i < C_RAM_WORDS; i++) begin
      fix_mem[i] = 32'h0;
      m_mem[i] = 32'h0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gpio", {24'd0, gpio}, 32'd0);
    chk("rst_irq",  {31'd0, irq}, 32'd0);
    chk("rst_done", {31'd0, tdone}, 32'd0);
    rst = 1'b0;

    // RAM write and readback
    step(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("t1_we",   {31'd0, ram_we}, 32'd1);
    chk("t1_addr", {22'd0, ram_addr}, 32'd4);
    step(1'b0, 4'h0, 32'h0000_0010, 32'h0);
    chk("t1_rd", cpu_rdata, 32'hDEAD_BEEF);

    // GPIO byte enables and width truncation
    step(1'b1, 4'h1, C_GPIO, 32'h0000_00A5);
    step(1'b1, 4'h2, C_GPIO, 32'hFFFF_FF00);
    chk("t2_gpio", {24'd0, gpio}, 32'h0000_00A5);
    step(1'b0, 4'h0, C_GPIO, 32'h0);
    chk("t2_rd", cpu_rdata, 32'h0000_00A5);

    // Timer compare interrupt
    step(1'b1, 4'hF, C_CMP, 32'd5);
    step(1'b1, 4'hF, C_COUNT, 32'd0);
    step(1'b1, 4'hF, C_CTRL, 32'd1);
    repeat (5) step(1'b0, 4'h0, 32'h0, 32'h0);
    chk("t3_irq_lo", {31'd0, irq}, 32'd0);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    chk("t3_irq_hi", {31'd0, irq}, 32'd1);
    repeat (3) step(1'b0, 4'h0, 32'h0, 32'h0);
    chk("t3_sticky", {31'd0, irq}, 32'd1);
    step(1'b1, 4'h1, C_CTRL, 32'd3);
    chk("t3_clr", {31'd0, irq}, 32'd0);
    step(1'b1, 4'hF, C_COUNT, 32'd5);
    step(1'b1, 4'h1, C_CTRL, 32'd3);
    chk("t3_setwins", {31'd0, irq}, 32'd1);

    // Counter wrap and load-over-increment
    step(1'b1, 4'hF, C_COUNT, 32'hFFFF_FFFE);
    step(1'b0, 4'h0, C_COUNT, 32'h0);
    chk("t4_rd0", cpu_rdata, 32'hFFFF_FFFE);
    step(1'b0, 4'h0, C_COUNT, 32'h0);
    chk("t4_rd1", cpu_rdata, 32'hFFFF_FFFF);
    step(1'b0, 4'h0, C_COUNT, 32'h0);
    chk("t4_wrap", cpu_rdata, 32'h0);
    step(1'b1, 4'hF, C_COUNT, 32'h0000_1234);
    step(1'b0, 4'h0, C_COUNT, 32'h0);
    chk("t4_load", cpu_rdata, 32'h0000_1234);

    // Test-status register
    step(1'b1, 4'hF, C_TEST, 32'd1);
    chk("t5_done", {31'd0, tdone}, 32'd1);
    chk("t5_pass", {31'd0, tpass}, 32'd1);
    step(1'b1, 4'hF, C_TEST, 32'd2);
    chk("t5_done2", {31'd0, tdone}, 32'd1);
    chk("t5_pass2", {31'd0, tpass}, 32'd0);

    // Asynchronous reset mid-cycle
    step(1'b1, 4'h1, C_GPIO, 32'h0000_00FF);
    step(1'b1, 4'hF, C_COUNT, 32'd5);
    step(1'b1, 4'hF, C_CMP, 32'd5);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    chk("t6_pre_irq", {31'd0, irq}, 32'd1);
    chk("t6_pre_gpio", {24'd0, gpio}, 32'h0000_00FF);
    #2 rst = 1'b1;
    #1;
    chk("t6_gpio", {24'd0, gpio}, 32'd0);
    chk("t6_irq",  {31'd0, irq}, 32'd0);
    chk("t6_done", {31'd0, tdone}, 32'd0);
    chk("t6_pass", {31'd0, tpass}, 32'd0);
    chk("t6_rdata", cpu_rdata, ram_rdata);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    step(1'b1, 4'hF, 32'h8000_0020, 32'hFFFF_FFFF);
    step(1'b0, 4'h0, 32'h8000_0020, 32'h0);
    chk("t6_unmapped", cpu_rdata, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        off = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 5);
        a = 32'h8000_0000 | (32'(off) << 2) | 32'($urandom_range(0, 3));
      end else begin
        a = $urandom;
        if (a[31:8] == 24'h80_0000) a[31] = 1'b0;
      end
      case ($urandom_range(0, 3))
        0: d = 32'($urandom_range(0, 15));
        1: d = 32'd1;
        default: d = $urandom;
      endcase
      step(($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), a, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
